// File: rtl/byte_reg_target_pkg.sv
// Shared definitions for the byte-wide register target: address map
// constants, responder FSM encoding and the STATUS byte packing helper.
package byte_reg_target_pkg;

  localparam logic [15:0] ADDR_TXDATA = 16'h0100;
  localparam logic [15:0] ADDR_STATUS = 16'h0101;
  localparam logic [15:0] ADDR_ID     = 16'h0102;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // STATUS layout: {full, empty, 2'b00, level[3:0]}
  function automatic logic [7:0] status_byte(input logic full,
                                             input logic empty,
                                             input logic [3:0] level);
    return {full, empty, 2'b00, level};
  endfunction

endpackage

// File: rtl/byte_sync_fifo.sv
// Single-clock byte FIFO. Pointers carry one extra wrap bit so that full
// and empty are told apart by the MSB compare. Pushes while full and pops
// while empty are ignored.
module byte_sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  output logic       full,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic [3:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] fill;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign fill    = wr_ptr_reg - rd_ptr_reg;
  assign level   = 4'(fill);
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];

  // Pointer update; reset flushes the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/byte_reg_target.sv
// Byte-wide request responder: scratch bytes, ID, STATUS and a TX FIFO.
// A transfer is captured in IDLE, waits WAIT_CYCLES+1 cycles in WAIT and
// completes with a single ready pulse in RESP, where the side effect is
// committed. All outputs decode registered state only, never valid.
module byte_reg_target
  import byte_reg_target_pkg::*;
#(
  parameter int         REG_NUM     = 4,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        read,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  output logic        err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  state_t      state_reg;
  state_t      state_next;
  logic [2:0]  wait_cnt_reg;
  logic [2:0]  wait_cnt_next;
  logic        capture;
  logic [15:0] addr_reg;
  logic        read_reg;
  logic [7:0]  wdata_reg;
  logic [7:0]  scratch_reg [REG_NUM];
  logic [7:0]  scratch_rd;

  logic        hit_scratch;
  logic        hit_tx;
  logic        hit_status;
  logic        hit_id;
  logic        resp_err;
  logic [7:0]  resp_data;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [3:0]  fifo_level;

  // FSM state, wait counter and captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      addr_reg     <= '0;
      read_reg     <= 1'b0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (capture) begin
        addr_reg  <= addr;
        read_reg  <= read;
        wdata_reg <= wdata;
      end
    end
  end

  // Next state: dropping valid in WAIT aborts with no side effect.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid) begin
          capture       = 1'b1;
          wait_cnt_next = 3'(WAIT_CYCLES);
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (!valid) begin
          state_next = IDLE;
        end else if (wait_cnt_reg == 3'd0) begin
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg - 3'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign hit_scratch = (addr_reg < 16'(REG_NUM));
  assign hit_tx      = (addr_reg == ADDR_TXDATA);
  assign hit_status  = (addr_reg == ADDR_STATUS);
  assign hit_id      = (addr_reg == ADDR_ID);

  // Scratch read mux over the captured address.
  always_comb begin
    scratch_rd = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (addr_reg == 16'(i)) scratch_rd = scratch_reg[i];
    end
  end

  // Response decode; anything not explicitly legal is an error.
  always_comb begin
    resp_err  = 1'b1;
    resp_data = '0;
    if (hit_scratch) begin
      resp_err = 1'b0;
      if (read_reg) resp_data = scratch_rd;
    end else if (hit_tx) begin
      // Fullness is the pre-cycle state; a same-cycle pop does not help.
      if (!read_reg && !fifo_full) resp_err = 1'b0;
    end else if (hit_status) begin
      if (read_reg) begin
        resp_err  = 1'b0;
        resp_data = status_byte(fifo_full, fifo_empty, fifo_level);
      end
    end else if (hit_id) begin
      if (read_reg) begin
        resp_err  = 1'b0;
        resp_data = ID_VALUE;
      end
    end
  end

  assign ready     = (state_reg == RESP);
  assign err       = ready && resp_err;
  assign rdata     = (ready && !resp_err) ? resp_data : 8'h00;
  assign fifo_push = ready && hit_tx && !read_reg && !fifo_full;

  // Scratch bytes commit on the RESP cycle of a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) scratch_reg[i] <= '0;
    end else if (ready && !read_reg && hit_scratch) begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (addr_reg == 16'(i)) scratch_reg[i] <= wdata_reg;
      end
    end
  end

  byte_sync_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (wdata_reg),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;
  // Storage is unreset, so hide it while nothing is queued.
  assign tx_data  = fifo_empty ? 8'h00 : fifo_rdata;

endmodule

// File: tb/tb_byte_reg_target.sv
// Directed plus randomized bench for byte_reg_target with a queue-based
// reference model of the register map and TX FIFO.
module tb_byte_reg_target;

  localparam int         W     = 2;
  localparam int         NREG  = 4;
  localparam int         DEPTH = 8;
  localparam logic [7:0] IDV   = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        read;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int vectors;
  int miscompares;

  logic [7:0] scratch_m [NREG];
  logic [7:0] q [$];
  logic [7:0] drained [$];
  bit         rand_txr;

  byte_reg_target #(
    .REG_NUM    (NREG),
    .FIFO_DEPTH (DEPTH),
    .WAIT_CYCLES(W),
    .ID_VALUE   (IDV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .read    (read),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // One clock: model pops/pushes at the edge, then check the TX stream.
  task automatic clk_step(input bit do_push = 1'b0, input logic [7:0] pv = 8'h00);
    bit pop;
    pop = tx_ready && (q.size() > 0);
    @(posedge clk);
    if (pop) begin
      drained.push_back(q[0]);
      void'(q.pop_front());
    end
    if (do_push) q.push_back(pv);
    @(negedge clk);
    chk("tx_valid", 8'(tx_valid), 8'(q.size() > 0));
    chk("tx_data", tx_data, (q.size() > 0) ? q[0] : 8'h00);
    if (rand_txr) tx_ready = 1'($urandom_range(0, 1));
  endtask

  // Full transfer: ready must stay low for W+1 cycles, pulse once, then drop.
  task automatic xfer(input bit rd, input logic [15:0] a, input logic [7:0] d,
                      input bit keep, input string tag,
                      output logic [7:0] got_rd, output logic got_err);
    logic [7:0] e_rd;
    bit         e_err;
    bit         push_it;
    valid = 1'b1; read = rd; addr = a; wdata = d;
    for (int k = 0; k <= W; k++) begin
      clk_step();
      chk({tag, "_rdy_wait"}, 8'(ready), 8'h00);
    end
    clk_step();
    e_rd = 8'h00; e_err = 1'b1; push_it = 1'b0;
    if (a < 16'(NREG)) begin
      e_err = 1'b0;
      if (rd) e_rd = scratch_m[int'(a)];
    end else if (a == 16'h0100) begin
      if (!rd && q.size() < DEPTH) begin e_err = 1'b0; push_it = 1'b1; end
    end else if (a == 16'h0101) begin
      if (rd) begin
        e_err = 1'b0;
        e_rd  = {q.size() == DEPTH, q.size() == 0, 2'b00, 4'(q.size())};
      end
    end else if (a == 16'h0102) begin
      if (rd) begin e_err = 1'b0; e_rd = IDV; end
    end
    got_rd  = rdata;
    got_err = err;
    chk({tag, "_ready"}, 8'(ready), 8'h01);
    chk({tag, "_err"}, 8'(err), 8'(e_err));
    chk({tag, "_rdata"}, rdata, e_rd);
    $display("xfer %s rd=%0d addr=0x%04h wdata=0x%02h -> rdata=0x%02h err=%0d",
             tag, rd, a, d, rdata, err);
    if (!keep) valid = 1'b0;
    clk_step(push_it, d);
    if (!rd && a < 16'(NREG)) scratch_m[int'(a)] = d;
    chk({tag, "_rdy_after"}, 8'(ready), 8'h00);
  endtask

  initial begin
    logic [7:0]  g_rd;
    logic        g_err;
    logic [15:0] ra;
    vectors = 0; miscompares = 0; rand_txr = 1'b0;
    rst_n = 1'b0; valid = 1'b0; read = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
    for (int i = 0; i < NREG; i++) scratch_m[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 8'(ready), 8'h00);
    chk("rst_err", 8'(err), 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;
    clk_step();

    // Scratch write / read back
    xfer(1'b0, 16'h0002, 8'h3C, 1'b0, "wr_s2", g_rd, g_err);
    xfer(1'b1, 16'h0002, 8'h00, 1'b0, "rd_s2", g_rd, g_err);
    chk("rd_s2_const", g_rd, 8'h3C);
    chk("rd_s2_err_const", 8'(g_err), 8'h00);

    // ID read, illegal ID write, ID unchanged
    xfer(1'b1, 16'h0102, 8'h00, 1'b0, "rd_id", g_rd, g_err);
    chk("rd_id_const", g_rd, 8'hA5);
    xfer(1'b0, 16'h0102, 8'h5A, 1'b0, "wr_id", g_rd, g_err);
    chk("wr_id_err_const", 8'(g_err), 8'h01);
    xfer(1'b1, 16'h0102, 8'h00, 1'b0, "rd_id2", g_rd, g_err);
    chk("rd_id2_const", g_rd, 8'hA5);

    // Fill FIFO with the sink stalled; ninth push overflows
    for (int i = 1; i <= 9; i++) begin
      xfer(1'b0, 16'h0100, 8'(i), 1'b0, "push", g_rd, g_err);
      chk("push_err_const", 8'(g_err), (i == 9) ? 8'h01 : 8'h00);
    end
    xfer(1'b1, 16'h0101, 8'h00, 1'b0, "st_full", g_rd, g_err);
    chk("status_full_const", g_rd, 8'h88);
    drained.delete();
    tx_ready = 1'b1;
    repeat (10) clk_step();
    tx_ready = 1'b0;
    chk("drain_count", 8'(drained.size()), 8'd8);
    for (int i = 0; i < 8 && i < drained.size(); i++) chk("drain_byte", drained[i], 8'(i + 1));
    xfer(1'b1, 16'h0101, 8'h00, 1'b0, "st_empty", g_rd, g_err);
    chk("status_empty_const", g_rd, 8'h40);

    // Unmapped read and TXDATA read are errors with zero data
    xfer(1'b1, 16'h0200, 8'h00, 1'b0, "rd_bad", g_rd, g_err);
    chk("rd_bad_err_const", 8'(g_err), 8'h01);
    chk("rd_bad_data_const", g_rd, 8'h00);
    xfer(1'b1, 16'h0100, 8'h00, 1'b0, "rd_tx", g_rd, g_err);
    chk("rd_tx_err_const", 8'(g_err), 8'h01);
    chk("rd_tx_data_const", g_rd, 8'h00);

    // Three back-to-back transfers with valid held high
    xfer(1'b0, 16'h0000, 8'h11, 1'b1, "b2b0", g_rd, g_err);
    xfer(1'b0, 16'h0003, 8'h33, 1'b1, "b2b1", g_rd, g_err);
    xfer(1'b1, 16'h0003, 8'h00, 1'b0, "b2b2", g_rd, g_err);
    chk("b2b2_const", g_rd, 8'h33);

    // Abort: drop valid during WAIT, no ready and no write
    valid = 1'b1; read = 1'b0; addr = 16'h0001; wdata = 8'hFF;
    clk_step();
    chk("abort_rdy0", 8'(ready), 8'h00);
    clk_step();
    chk("abort_rdy1", 8'(ready), 8'h00);
    valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      clk_step();
      chk("abort_rdy_idle", 8'(ready), 8'h00);
    end
    xfer(1'b1, 16'h0001, 8'h00, 1'b0, "abort_chk", g_rd, g_err);
    chk("abort_reg_const", g_rd, 8'h00);

    // Reset during WAIT with three bytes queued
    for (int i = 0; i < 3; i++) xfer(1'b0, 16'h0100, 8'(8'hC0 + i), 1'b0, "pre_rst", g_rd, g_err);
    valid = 1'b1; read = 1'b1; addr = 16'h0101;
    clk_step();
    clk_step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 8'(ready), 8'h00);
    chk("mid_rst_tx_valid", 8'(tx_valid), 8'h00);
    valid = 1'b0;
    q.delete();
    for (int i = 0; i < NREG; i++) scratch_m[i] = 8'h00;
    @(negedge clk);
    chk("in_rst_ready", 8'(ready), 8'h00);
    rst_n = 1'b1;
    clk_step();
    chk("post_rst_ready", 8'(ready), 8'h00);
    xfer(1'b1, 16'h0101, 8'h00, 1'b0, "st_post_rst", g_rd, g_err);
    chk("status_post_rst_const", g_rd, 8'h40);
    xfer(1'b1, 16'h0000, 8'h00, 1'b0, "s0_post_rst", g_rd, g_err);
    chk("s0_post_rst_const", g_rd, 8'h00);

    // Randomized traffic with a randomly stalling sink
    rand_txr = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    ra = 16'($urandom_range(0, NREG - 1));
        2:       ra = 16'(NREG);
        3, 4:    ra = 16'h0100;
        5:       ra = 16'h0101;
        6:       ra = 16'h0102;
        default: ra = 16'($urandom);
      endcase
      xfer(1'($urandom_range(0, 1)), ra, 8'($urandom), 1'($urandom_range(0, 1)),
           "rnd", g_rd, g_err);
    end
    valid = 1'b0;
    rand_txr = 1'b0;
    tx_ready = 1'b1;
    repeat (12) clk_step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
